i2c_master_ctrl: RTL and testbench

Single-byte I2C master that generates SCL and SDA_out from the system clock and samples SDA_in from the slave. It sits directly upstream of the EEPROM slave model and drives its SCL/SDA_out inputs. It performs register writes (dev, reg, data) and register reads (dev, reg, repeated start, dev+R, data) under a start/busy/done handshake. ACK errors are reported to the host.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_quarter_gen.sv | 49 ++++
 rtl/i2c_master_ctrl.sv | 171 +++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C master types: FSM states, quarter indices and rw encodings.
// No logic; imported by the controller and its quarter generator.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        DEV,
        ACK_DEV,
        REG,
        ACK_REG,
        WRITE,
        ACK_DATA,
        RESTART,
        DEV_R,
        ACK_DEV_R,
        READ,
        MNACK,
        STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_quarter_gen.sv
// Bit-slot timebase: CLK_DIV clocks per quarter, four quarters per slot.
// Latency: strobes are combinational from the counters; held at Q0/count 0 while en=0.
module i2c_quarter_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] quarter,
    output logic       quarter_end,
    output logic       slot_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    quarter_q, quarter_d;

    always_comb begin
        quarter_end = en && (cnt_q == CW'(CLK_DIV - 1));
        slot_end    = quarter_end && (quarter_q == Q3);
        cnt_d       = cnt_q;
        quarter_d   = quarter_q;
        if (!en) begin
            cnt_d     = '0;
            quarter_d = Q0;
        end else if (quarter_end) begin
            cnt_d     = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            quarter_q <= Q0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

    assign quarter = quarter_q;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C register write/read master with ACK-error reporting.
// Latency: 29 (write), 39 (read) or 11 (device NACK) slots of 4*CLK_DIV clocks; start is ignored while busy.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    output logic       SDA_out,
    input  logic       SDA_in
);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ack_err_q, ack_err_d;

    logic [1:0] quarter;
    logic       quarter_end;
    logic       slot_end;
    logic       sample_pt;
    logic       is_ack;
    logic       is_byte;
    logic [7:0] tx_byte;

    i2c_quarter_gen #(.CLK_DIV(CLK_DIV)) u_qgen (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q != IDLE),
        .quarter     (quarter),
        .quarter_end (quarter_end),
        .slot_end    (slot_end)
    );

    assign sample_pt = (quarter == Q1) && quarter_end;
    assign is_ack    = (state_q == ACK_DEV) || (state_q == ACK_REG) ||
                       (state_q == ACK_DATA) || (state_q == ACK_DEV_R);
    assign is_byte   = (state_q == DEV) || (state_q == REG) || (state_q == WRITE) ||
                       (state_q == DEV_R) || (state_q == READ);

    always_comb begin
        tx_byte = 8'hFF;
        case (state_q)
            DEV:     tx_byte = {dev_q, RW_WRITE};
            REG:     tx_byte = reg_q;
            WRITE:   tx_byte = wdata_q;
            DEV_R:   tx_byte = {dev_q, RW_READ};
            default: tx_byte = 8'hFF;
        endcase
    end

    // Start/restart/stop edges fall in Q2 while SCL is high; data changes only at Q0.
    always_comb begin
        SCL     = (state_q == IDLE) || (quarter == Q1) || (quarter == Q2);
        SDA_out = 1'b1;
        case (state_q)
            START, RESTART:            SDA_out = !quarter[1];
            STOP:                      SDA_out = quarter[1];
            DEV, REG, WRITE, DEV_R:    SDA_out = tx_byte[bit_cnt_q];
            default:                   SDA_out = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d   = START;
                bit_cnt_d = 3'd7;
                rw_d      = rw;
                dev_d     = dev_addr;
                reg_d     = reg_addr;
                wdata_d   = wdata;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
            end
        end else begin
            if (sample_pt) begin
                if (is_ack) ack_err_d = ack_err_q | SDA_in;
                if (state_q == READ) shift_d = {shift_q[6:0], SDA_in};
            end
            if (slot_end) begin
                // 3'd0 - 1 wraps back to 7, re-arming the counter for the next byte.
                if (is_byte) bit_cnt_d = bit_cnt_q - 3'd1;
                case (state_q)
                    START:     state_d = DEV;
                    DEV:       if (bit_cnt_q == 3'd0) state_d = ACK_DEV;
                    ACK_DEV:   state_d = ack_err_q ? STOP : REG;
                    REG:       if (bit_cnt_q == 3'd0) state_d = ACK_REG;
                    ACK_REG:   state_d = ack_err_q ? STOP : ((rw_q == RW_READ) ? RESTART : WRITE);
                    WRITE:     if (bit_cnt_q == 3'd0) state_d = ACK_DATA;
                    ACK_DATA:  state_d = STOP;
                    RESTART:   state_d = DEV_R;
                    DEV_R:     if (bit_cnt_q == 3'd0) state_d = ACK_DEV_R;
                    ACK_DEV_R: state_d = ack_err_q ? STOP : READ;
                    READ:      if (bit_cnt_q == 3'd0) state_d = MNACK;
                    MNACK:     state_d = STOP;
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if ((rw_q == RW_READ) && !ack_err_q) rdata_d = shift_q;
                    end
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rw_q      <= RW_WRITE;
            dev_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level slave/monitor plus a queue of expected transaction results.
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int MAXC    = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy, done, ack_err, SCL, SDA_out;
    logic       SDA_in = 1'b1;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .SCL      (SCL),
        .SDA_out  (SDA_out),
        .SDA_in   (SDA_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        ack_err;
        logic [7:0]  rdata;
        int          nbytes;
        logic [31:0] bytes;
        int          starts;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // slave / bus monitor state
    logic        p_scl = 1'b1, p_sda = 1'b1;
    logic        sl_active = 1'b0, nack_mode = 1'b0, mnack_sda = 1'b0;
    logic [7:0]  rd_byte = '0, acc = '0, model_rdata = '0;
    logic [31:0] mon_bytes = '0;
    int          mon_nbytes = 0, bit_n = 0, slot = 0;
    int          n_start = 0, n_stop = 0, hi_len = 0, n_hi = 0, hi_bad = 0, done_cnt = 0;
    logic        hi_busy = 1'b0;

    function automatic logic slave_bit();
        if (!sl_active || nack_mode) return 1'b1;
        if (n_start >= 2) begin
            if (slot == 8) return 1'b0;
            if (slot >= 9 && slot <= 16) return rd_byte[16 - slot];
            return 1'b1;
        end
        return (slot % 9 == 8) ? 1'b0 : 1'b1;
    endfunction

    task automatic tick();
        logic scl, sda;
        @(negedge clk);
        scl = SCL;
        sda = SDA_out;
        if (done === 1'b1) done_cnt++;
        if (p_scl && scl) begin
            hi_len++;
            if (busy !== 1'b1) hi_busy = 1'b0;
            if (p_sda && !sda) begin
                n_start++;
                sl_active = 1'b1;
                slot = 0;
                bit_n = 0;
            end else if (!p_sda && sda) begin
                n_stop++;
                sl_active = 1'b0;
                SDA_in = 1'b1;
            end
        end else if (!p_scl && scl) begin
            hi_len = 1;
            hi_busy = (busy === 1'b1);
            if (sl_active) begin
                if (slot % 9 == 8) begin
                    if (n_start >= 2 && slot == 17) mnack_sda = sda;
                end else begin
                    acc = {acc[6:0], sda};
                    bit_n++;
                    if (bit_n == 8) begin
                        mon_bytes = {mon_bytes[23:0], acc};
                        mon_nbytes++;
                        bit_n = 0;
                    end
                end
                slot++;
            end
        end else if (p_scl && !scl) begin
            if (hi_busy) begin
                n_hi++;
                if (hi_len != 2 * CLK_DIV) hi_bad++;
            end
            SDA_in = slave_bit();
        end
        p_scl = scl;
        p_sda = sda;
    endtask

    task automatic mon_clear();
        n_start = 0; n_stop = 0; slot = 0; bit_n = 0; acc = '0;
        mon_bytes = '0; mon_nbytes = 0; n_hi = 0; hi_bad = 0;
        mnack_sda = 1'b0; sl_active = 1'b0; SDA_in = 1'b1;
    endtask

    // Pushes the expected outcome, then drives a one-cycle start and scrambles the inputs.
    task automatic issue(input logic rw_i, input logic [6:0] d, input logic [7:0] r,
                         input logic [7:0] w, input logic [7:0] rd, input logic nack);
        exp_t e;
        mon_clear();
        nack_mode = nack;
        rd_byte = rd;
        e.lat = (nack ? 11 : (rw_i ? 39 : 29)) * 4 * CLK_DIV;
        e.ack_err = nack;
        if (nack) begin
            e.nbytes = 1; e.bytes = {24'h0, d, 1'b0}; e.starts = 1;
        end else if (rw_i) begin
            e.nbytes = 4; e.bytes = {d, 1'b0, r, d, 1'b1, 8'hFF}; e.starts = 2;
            model_rdata = rd;
        end else begin
            e.nbytes = 3; e.bytes = {8'h00, d, 1'b0, r, w}; e.starts = 1;
        end
        e.rdata = model_rdata;
        sb.push_back(e);
        rw = rw_i; dev_addr = d; reg_addr = r; wdata = w; start = 1'b1;
        tick();
        start = 1'b0; rw = ~rw_i; dev_addr = ~d; reg_addr = ~r; wdata = ~w;
    endtask

    task automatic run_until_done(input int max, output int lat_o, output bit got);
        got = 1'b0;
        lat_o = 0;
        while (!got && lat_o < max) begin
            tick();
            lat_o++;
            got = (done === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({SCL, SDA_out, busy, done, ack_err} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl: got SCL/SDA/busy/done/ack_err=%b required 11000",
                     {SCL, SDA_out, busy, done, ack_err});
        end
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL reset_rdata: got %h required 00", rdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write();
        exp_t e; int lat; bit got;
        issue(RW_WRITE, 7'h7F, 8'hA5, 8'h3C, 8'h00, 1'b0);
        run_until_done(MAXC, lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++; $display("FAIL write_latency: got %0d (seen=%0b) required %0d", lat, got, e.lat);
        end
        checks++;
        if (mon_nbytes != e.nbytes || mon_bytes !== e.bytes) begin
            errors++; $display("FAIL write_bytes: got %0d/%h required %0d/%h", mon_nbytes, mon_bytes, e.nbytes, e.bytes);
        end
        checks++;
        if (ack_err !== e.ack_err || busy !== 1'b0) begin
            errors++; $display("FAIL write_status: got ack_err=%b busy=%b required %b 0", ack_err, busy, e.ack_err);
        end
        checks++;
        if (n_start != e.starts || n_stop != 1 || hi_bad != 0 || n_hi == 0) begin
            errors++; $display("FAIL write_protocol: got starts=%0d stops=%0d bad_high=%0d highs=%0d required %0d 1 0 >0",
                               n_start, n_stop, hi_bad, n_hi, e.starts);
        end
    endtask

    task automatic test_read();
        exp_t e; int lat; bit got;
        issue(RW_READ, 7'h7F, 8'h10, 8'h00, 8'hC3, 1'b0);
        run_until_done(MAXC, lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++; $display("FAIL read_latency: got %0d (seen=%0b) required %0d", lat, got, e.lat);
        end
        checks++;
        if (mon_nbytes != e.nbytes || mon_bytes !== e.bytes) begin
            errors++; $display("FAIL read_bytes: got %0d/%h required %0d/%h", mon_nbytes, mon_bytes, e.nbytes, e.bytes);
        end
        checks++;
        if (rdata !== e.rdata || ack_err !== e.ack_err) begin
            errors++; $display("FAIL read_data: got rdata=%h ack_err=%b required %h %b", rdata, ack_err, e.rdata, e.ack_err);
        end
        checks++;
        if (n_start != e.starts || n_stop != 1 || hi_bad != 0 || mnack_sda !== 1'b1) begin
            errors++; $display("FAIL read_protocol: got starts=%0d stops=%0d bad_high=%0d mnack=%b required %0d 1 0 1",
                               n_start, n_stop, hi_bad, mnack_sda, e.starts);
        end
    endtask

    task automatic test_dev_nack();
        exp_t e; int lat; bit got;
        issue(RW_WRITE, 7'h12, 8'h44, 8'h55, 8'h00, 1'b1);
        run_until_done(MAXC, lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++; $display("FAIL nack_latency: got %0d (seen=%0b) required %0d", lat, got, e.lat);
        end
        checks++;
        if (ack_err !== e.ack_err || rdata !== e.rdata) begin
            errors++; $display("FAIL nack_status: got ack_err=%b rdata=%h required %b %h", ack_err, rdata, e.ack_err, e.rdata);
        end
        checks++;
        if (mon_nbytes != e.nbytes || mon_bytes !== e.bytes || n_stop != 1 || hi_bad != 0) begin
            errors++; $display("FAIL nack_bus: got %0d/%h stops=%0d bad_high=%0d required %0d/%h 1 0",
                               mon_nbytes, mon_bytes, n_stop, hi_bad, e.nbytes, e.bytes);
        end
        nack_mode = 1'b0;
    endtask

    task automatic test_start_while_busy();
        exp_t e; int lat; bit got; int dc0;
        dc0 = done_cnt;
        issue(RW_WRITE, 7'h2A, 8'h21, 8'h9A, 8'h00, 1'b0);
        repeat (100) tick();
        rw = RW_READ; dev_addr = 7'h11; reg_addr = 8'hEE; wdata = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(MAXC, lat, got);
        lat = lat + 101;
        e = sb.pop_front();
        repeat (50) tick();
        checks++;
        if (!got || lat != e.lat) begin
            errors++; $display("FAIL busy_latency: got %0d (seen=%0b) required %0d", lat, got, e.lat);
        end
        checks++;
        if (mon_nbytes != e.nbytes || mon_bytes !== e.bytes) begin
            errors++; $display("FAIL busy_bytes: got %0d/%h required %0d/%h", mon_nbytes, mon_bytes, e.nbytes, e.bytes);
        end
        checks++;
        if (done_cnt - dc0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_done_count: got %0d busy=%b required 1 0", done_cnt - dc0, busy);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat; bit got; int i; int dc0;
        issue(RW_WRITE, 7'h33, 8'h5C, 8'h81, 8'h00, 1'b0);
        i = 0;
        while (!(mon_nbytes == 1 && bit_n == 3) && i < MAXC) begin
            tick();
            i++;
        end
        checks++;
        if (i >= MAXC) begin
            errors++; $display("FAIL reset_mid_reach: got no REG byte within %0d clocks required REG bit 3", MAXC);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({SCL, SDA_out, busy, done} !== 4'b1100) begin
            errors++; $display("FAIL reset_mid_lines: got SCL/SDA/busy/done=%b required 1100", {SCL, SDA_out, busy, done});
        end
        rst = 1'b1;
        model_rdata = 8'h00;
        e = sb.pop_front();
        dc0 = done_cnt;
        repeat (300) tick();
        checks++;
        if (done_cnt != dc0 || rdata !== 8'h00) begin
            errors++; $display("FAIL reset_mid_no_done: got dones=%0d rdata=%h required 0 00", done_cnt - dc0, rdata);
        end
        issue(RW_WRITE, 7'h33, 8'h5C, 8'h81, 8'h00, 1'b0);
        run_until_done(MAXC, lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat || mon_bytes !== e.bytes || ack_err !== e.ack_err) begin
            errors++; $display("FAIL reset_mid_recover: got lat=%0d bytes=%h ack_err=%b required %0d %h %b",
                               lat, mon_bytes, ack_err, e.lat, e.bytes, e.ack_err);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; bit got;
        issue(RW_WRITE, 7'h50, 8'h07, 8'hE1, 8'h00, 1'b0);
        run_until_done(MAXC, lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat || mon_bytes !== e.bytes) begin
            errors++; $display("FAIL b2b_write: got lat=%0d bytes=%h required %0d %h", lat, mon_bytes, e.lat, e.bytes);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL b2b_done_pulse: got done=%b one cycle later required 0", done);
        end
        issue(RW_READ, 7'h50, 8'h07, 8'h00, 8'h5A, 1'b0);
        run_until_done(MAXC, lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat || rdata !== e.rdata || mon_bytes !== e.bytes) begin
            errors++; $display("FAIL b2b_read: got lat=%0d rdata=%h bytes=%h required %0d %h %h",
                               lat, rdata, mon_bytes, e.lat, e.rdata, e.bytes);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_dev_nack();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
